// File: rtl/perf_counter_bank.sv
// Bank of 16-bit rising-edge event counters behind a single-request/response
// memory-mapped window: counters, sticky overflow bits and an enable flag.
module perf_counter_bank #(
  parameter int          NUM_CTR   = 8,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CTR-1:0] event_in,
  input  logic [15:0]        mem_address,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [15:0]        mem_wdata,
  output logic               mem_sel,
  output logic [15:0]        mem_rdata,
  output logic               mem_resp
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  localparam logic [3:0] OVF_IDX  = 4'(NUM_CTR);
  localparam logic [3:0] CTRL_IDX = 4'(NUM_CTR + 1);

  state_t                    state_q, state_d;
  logic [NUM_CTR-1:0][15:0]  ctr_q, ctr_d;
  logic [NUM_CTR-1:0]        ovf_q, ovf_d;
  logic [NUM_CTR-1:0]        prev_q, prev_d;
  logic                      en_q, en_d;
  logic                      resp_q, resp_d;
  logic [15:0]               rdata_q, rdata_d;

  logic [3:0]                word_s;
  logic                      accept_s;
  logic                      wr_s;
  logic [NUM_CTR-1:0]        edge_s;
  logic [NUM_CTR-1:0]        wrap_s;
  logic [NUM_CTR-1:0]        ovf_clr_s;
  logic [15:0]               rd_val_s;
  logic                      unused_s;

  assign mem_sel   = (mem_address[15:5] == BASE_ADDR[15:5]);
  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;
  assign unused_s  = ^{mem_address[0], mem_wdata};

  // Request decode: a transaction is taken only from IDLE; read+write counts as a write
  always_comb begin
    word_s   = mem_address[4:1];
    accept_s = (state_q == ST_IDLE) && mem_sel && (mem_read || mem_write);
    wr_s     = accept_s && mem_write;
  end

  // Read mux, sampled before this cycle's edges are applied
  always_comb begin
    rd_val_s = 16'h0000;
    if (word_s == OVF_IDX) begin
      for (int i = 0; i < NUM_CTR; i++) begin
        rd_val_s[i] = ovf_q[i];
      end
    end else if (word_s == CTRL_IDX) begin
      rd_val_s[0] = en_q;
    end else begin
      for (int i = 0; i < NUM_CTR; i++) begin
        rd_val_s = (word_s == 4'(i)) ? ctr_q[i] : rd_val_s;
      end
    end
  end

  // Counter update: a software clear beats a same-cycle edge
  always_comb begin
    ctr_d  = ctr_q;
    edge_s = {NUM_CTR{1'b0}};
    wrap_s = {NUM_CTR{1'b0}};
    for (int i = 0; i < NUM_CTR; i++) begin
      edge_s[i] = event_in[i] & ~prev_q[i];
      if (wr_s && (word_s == 4'(i))) begin
        ctr_d[i] = 16'h0000;
      end else if (edge_s[i] && en_q) begin
        ctr_d[i]  = ctr_q[i] + 16'd1;
        wrap_s[i] = (ctr_q[i] == 16'hFFFF);
      end else begin
        ctr_d[i] = ctr_q[i];
      end
    end
    ovf_clr_s = (wr_s && (word_s == OVF_IDX)) ? mem_wdata[NUM_CTR-1:0] : {NUM_CTR{1'b0}};
    // a wrap in the same cycle as a W1C keeps the overflow bit set
    ovf_d  = (ovf_q & ~ovf_clr_s) | wrap_s;
    en_d   = (wr_s && (word_s == CTRL_IDX)) ? mem_wdata[0] : en_q;
    prev_d = event_in;
  end

  // Handshake FSM: IDLE accepts and captures, RESP presents a one-cycle pulse
  always_comb begin
    state_d = state_q;
    resp_d  = 1'b0;
    rdata_d = 16'h0000;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_RESP;
          resp_d  = 1'b1;
          rdata_d = mem_write ? 16'h0000 : rd_val_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ctr_q   <= {NUM_CTR{16'h0000}};
      ovf_q   <= {NUM_CTR{1'b0}};
      prev_q  <= {NUM_CTR{1'b1}};
      en_q    <= 1'b1;
      resp_q  <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      ovf_q   <= ovf_d;
      prev_q  <= prev_d;
      en_q    <= en_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
